// File: rtl/nerd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nerd_pkg                                                                   |
// | Shared sprite geometry defaults, palette constants and animation states.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package nerd_pkg;

  localparam int         SPRITE_W_DEF        = 32;
  localparam int         SPRITE_H_DEF        = 32;
  localparam logic [3:0] TRANSPARENT_IDX_DEF = 4'd5;
  localparam int         FRAME_COUNT         = 4;
  localparam logic [1:0] FRAME_LAST          = 2'(FRAME_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOP    = 2'd1,
    ONESHOT = 2'd2
  } anim_state_t;

endpackage
`default_nettype wire

// File: rtl/nerd_anim_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nerd_anim_fsm                                                              |
// | Animation sequencer: frame_start divider plus IDLE/LOOP/ONESHOT control.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nerd_anim_fsm
  import nerd_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_start,
  input  logic        i_anim_run,
  input  logic        i_trigger,
  output logic [1:0]  o_frame,
  output logic [1:0]  o_frame_next,
  output anim_state_t o_state
);

  localparam int               DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(ANIM_DIV - 1);

  anim_state_t      r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [1:0]       r_frame, w_frame_nxt;
  logic             w_div_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  // Trigger outranks everything, so a coincident frame_start is not counted.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_frame_nxt = r_frame;
    w_div_done  = i_frame_start && (r_div == c_DIV_LAST);
    case (r_state)
      IDLE: begin
        w_div_nxt   = '0;
        w_frame_nxt = '0;
        if (i_trigger) begin
          w_state_nxt = ONESHOT;
        end else if (i_anim_run) begin
          w_state_nxt = LOOP;
        end
      end
      LOOP: begin
        if (i_trigger) begin
          w_state_nxt = ONESHOT;
          w_div_nxt   = '0;
          w_frame_nxt = '0;
        end else if (!i_anim_run) begin
          w_state_nxt = IDLE;
          w_div_nxt   = '0;
          w_frame_nxt = '0;
        end else if (i_frame_start) begin
          if (w_div_done) begin
            w_div_nxt   = '0;
            w_frame_nxt = r_frame + 2'd1;
          end else begin
            w_div_nxt = r_div + 1'b1;
          end
        end
      end
      ONESHOT: begin
        if (i_trigger) begin
          w_div_nxt   = '0;
          w_frame_nxt = '0;
        end else if (i_frame_start) begin
          if (w_div_done) begin
            w_div_nxt = '0;
            if (r_frame == FRAME_LAST) begin
              w_state_nxt = IDLE;
              w_frame_nxt = '0;
            end else begin
              w_frame_nxt = r_frame + 2'd1;
            end
          end else begin
            w_div_nxt = r_div + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_div_nxt   = '0;
        w_frame_nxt = '0;
      end
    endcase
  end

  assign o_frame      = r_frame;
  assign o_frame_next = w_frame_nxt;
  assign o_state      = r_state;

endmodule
`default_nettype wire

// File: rtl/nerd_sprite_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nerd_sprite_fetch                                                          |
// | Sprite hit test, ROM address generation and 3-cycle palette index pipe.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nerd_sprite_fetch
  import nerd_pkg::*;
#(
  parameter int         SPRITE_W        = SPRITE_W_DEF,
  parameter int         SPRITE_H        = SPRITE_H_DEF,
  parameter int         ANIM_DIV        = 8,
  parameter logic [3:0] TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
  localparam int        COL_W           = $clog2(SPRITE_W),
  localparam int        ROW_W           = $clog2(SPRITE_H),
  localparam int        ADDR_W          = 2 + ROW_W + COL_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              enable,
  input  logic              flip_x,
  input  logic              anim_run,
  input  logic              trigger,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        index,
  output logic              opaque,
  output logic              out_valid,
  output logic [1:0]        anim_frame,
  output logic [1:0]        anim_state
);

  localparam logic [10:0]      c_W11      = 11'(SPRITE_W);
  localparam logic [10:0]      c_H11      = 11'(SPRITE_H);
  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(SPRITE_W - 1);

  logic              r_sh_en, r_sh_flip;
  logic [9:0]        r_sh_x, r_sh_y;
  logic [1:0]        r_sh_frame;
  logic [1:0]        w_frame_next;
  anim_state_t       w_state;
  logic [COL_W-1:0]  w_dx, w_col;
  logic [ROW_W-1:0]  w_row;
  logic              w_in_x, w_in_y, w_hit;
  logic              r_hit1, r_hit2, r_val1, r_val2;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [3:0]        r_index;
  logic              r_opaque, r_out_valid;

  nerd_anim_fsm #(
    .ANIM_DIV (ANIM_DIV)
  ) u_anim (
    .clk          (Clk),
    .rst          (Reset),
    .i_frame_start(frame_start),
    .i_anim_run   (anim_run),
    .i_trigger    (trigger),
    .o_frame      (anim_frame),
    .o_frame_next (w_frame_next),
    .o_state      (w_state)
  );

  // Upper bounds are compared in 11 bits so a sprite near 1023 clips instead of wrapping.
  assign w_in_x = (DrawX >= r_sh_x) && ({1'b0, DrawX} < ({1'b0, r_sh_x} + c_W11));
  assign w_in_y = (DrawY >= r_sh_y) && ({1'b0, DrawY} < ({1'b0, r_sh_y} + c_H11));
  assign w_hit  = pix_valid && r_sh_en && w_in_x && w_in_y;
  assign w_dx   = COL_W'(DrawX - r_sh_x);
  assign w_row  = ROW_W'(DrawY - r_sh_y);
  assign w_col  = r_sh_flip ? (c_COL_LAST - w_dx) : w_dx;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sh_en     <= 1'b0;
      r_sh_flip   <= 1'b0;
      r_sh_x      <= '0;
      r_sh_y      <= '0;
      r_sh_frame  <= '0;
      r_rom_addr  <= '0;
      r_hit1      <= 1'b0;
      r_hit2      <= 1'b0;
      r_val1      <= 1'b0;
      r_val2      <= 1'b0;
      r_index     <= '0;
      r_opaque    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // The frame is latched with the geometry so the picture never tears.
      if (frame_start) begin
        r_sh_en    <= enable;
        r_sh_flip  <= flip_x;
        r_sh_x     <= pos_x;
        r_sh_y     <= pos_y;
        r_sh_frame <= w_frame_next;
      end
      if (w_hit) begin
        r_rom_addr <= {r_sh_frame, w_row, w_col};
      end
      r_hit1      <= w_hit;
      r_val1      <= pix_valid;
      r_hit2      <= r_hit1;
      r_val2      <= r_val1;
      r_index     <= r_hit2 ? rom_data : 4'd0;
      r_opaque    <= r_hit2 && (rom_data != TRANSPARENT_IDX);
      r_out_valid <= r_val2;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign index      = r_index;
  assign opaque     = r_opaque;
  assign out_valid  = r_out_valid;
  assign anim_state = w_state;

endmodule
`default_nettype wire

// File: doc/nerd_sprite_fetch.md
NERD_SPRITE_FETCH -- requirements
Module: nerd_sprite_fetch

Interface
REQ-001 SHALL have parameter SPRITE_W, default 32, sprite width in pixels (power of two).
REQ-002 SHALL have parameter SPRITE_H, default 32, sprite height in pixels (power of two).
REQ-003 SHALL have parameter ANIM_DIV, default 8, frame_start pulses per animation step.
REQ-004 SHALL have parameter TRANSPARENT_IDX, default 4'd5, palette index treated as see-through.
REQ-005 Clk  input  1  single clock; all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high.
REQ-007 frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-008 pix_valid  input  1  DrawX/DrawY is inside the active video region.
REQ-009 DrawX, DrawY  input  10 each  current pixel coordinate.
REQ-010 pos_x, pos_y  input  10 each  requested sprite top-left corner.
REQ-011 enable  input  1  sprite shown this frame.
REQ-012 flip_x  input  1  horizontal mirror.
REQ-013 anim_run  input  1  loop the animation.
REQ-014 trigger  input  1  one-cycle pulse requesting a single animation pass.
REQ-015 rom_addr  output  12  sprite ROM address {frame[1:0], row[4:0], col[4:0]}.
REQ-016 rom_data  input  4  palette index; synchronous ROM, 1-cycle read latency.
REQ-017 index  output  4  palette index for the downstream palette lookup.
REQ-018 opaque  output  1  index is a visible sprite pixel.
REQ-019 out_valid  output  1  pix_valid delayed to align with index/opaque.

Function
REQ-020 pos_x, pos_y, enable and flip_x SHALL be sampled into shadow registers only on cycles with frame_start=1; hit testing SHALL use shadow values only.
REQ-021 Hit condition SHALL be pix_valid, shadow enable, pos_x <= DrawX < pos_x+SPRITE_W and pos_y <= DrawY < pos_y+SPRITE_H, with the sums in 11 bits so there is no wrap; the sprite is clipped at the right and bottom edges.
REQ-022 col SHALL be DrawX-pos_x, or SPRITE_W-1-(DrawX-pos_x) when shadow flip_x=1; row SHALL be DrawY-pos_y.
REQ-023 rom_addr SHALL be registered at the edge ending input cycle t; when there is no hit, rom_addr SHALL hold its previous value.
REQ-024 index, opaque and out_valid SHALL be registered and SHALL present data for input cycle t during cycle t+3 (fixed 3-cycle latency, no bubbles, one pixel per cycle).
REQ-025 On a hit, index SHALL equal rom_data and opaque SHALL be (rom_data != TRANSPARENT_IDX); on a miss, index SHALL be 0 and opaque SHALL be 0.
REQ-026 The animation FSM SHALL have the states IDLE, LOOP and ONESHOT; the current frame is 2 bits; the divider counts frame_start pulses from 0 to ANIM_DIV-1.
REQ-027 IDLE: frame=0 and divider=0; trigger goes to ONESHOT; otherwise anim_run=1 goes to LOOP.
REQ-028 LOOP: on the frame_start that completes the divider, frame advances and wraps 3->0; anim_run=0 goes to IDLE, resetting frame and divider; trigger goes to ONESHOT, resetting frame and divider.
REQ-029 ONESHOT: frame advances as in LOOP; the divider completion at frame=3 goes to IDLE with frame=0; trigger during ONESHOT restarts at frame 0; anim_run is ignored.
REQ-030 If trigger and frame_start occur in the same cycle, trigger SHALL take priority and the divider SHALL NOT count that pulse.
REQ-031 The frame value used in rom_addr SHALL change only at frame_start, so no frame tears mid-picture.

Reset
REQ-032 Reset SHALL clear rom_addr, index, opaque, out_valid, all pipeline registers, all shadow registers, the divider and frame, and SHALL put the FSM in IDLE.
REQ-033 Reset asserted mid-frame SHALL force zero outputs on the next cycle; the sprite SHALL be hidden until the first frame_start after Reset is released.

Structure
REQ-034 The package nerd_pkg SHALL hold SPRITE_W/SPRITE_H defaults, TRANSPARENT_IDX, the frame count (4) and the anim_state_t enum {IDLE, LOOP, ONESHOT}.
REQ-035 The animation FSM and divider SHALL be a sub-module nerd_anim_fsm with outputs frame[1:0] and state.

Verification
REQ-036 Shadow and flip: pos=(100,50), enable=1, flip_x=0, frame_start, then DrawX=100, DrawY=50 -> rom_addr=0x000 at t+1; with rom_data=4'h2, index=2 and opaque=1 at t+3; with flip_x=1 from the next frame, rom_addr=0x01F.
REQ-037 Transparency and miss: on a hit with rom_data=4'h5 -> opaque=0 and index=5; at DrawX=132 (outside the sprite) -> index=0 and opaque=0.
REQ-038 Clipping: pos_x=630, DrawX=639 -> hit with col=9; pos_x=1020, DrawX=3 -> no hit.
REQ-039 Loop: anim_run=1, ANIM_DIV=8 -> frame 1 after the 8th frame_start, and 3->0 after the 32nd; deassert anim_run -> IDLE with frame=0.
REQ-040 One-shot and priority: trigger coincident with frame_start while in LOOP at frame=2 -> frame=0 and divider=0; after 32 further frame_start pulses -> IDLE with frame=0. Reset in mid-picture -> all outputs 0 next cycle, and no hit until the next frame_start.
